// File: rtl/prio_enc_queue.sv
// prio_enc_queue
// ----------------------------------------------------------------------------
// Registered priority encoder that captures request pulses into a sticky
// pending register. It hands out one granted channel index per cycle through
// a valid/ready output register and holds the grant while the consumer stalls.
//
// Parameters
//   N      number of request channels (2..64)
//   IDX_W  derived width of out_idx  ($clog2(N))
//   CNT_W  derived width of pend_cnt ($clog2(N+1))
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_in      request pulses, one per channel, captured every edge
//   out_valid   output register holds a grant
//   out_ready   consumer accepts the grant this cycle
//   out_idx     granted channel index
//   out_onehot  one-hot form of out_idx
//   pend_cnt    registered count of pending channels
//   pend_any    some channel is pending
//
// Configuration
//   PRIO_ENC_RR_EN  when defined, selection is round-robin: the search starts
//                   one below the last granted index and walks downward with
//                   wrap. When undefined, the highest pending index always wins.
// ----------------------------------------------------------------------------
module prio_enc_queue #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             pend_any
);

    // The output register is either empty or holding one grant.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     pending;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     pop_mask;
    logic [IDX_W-1:0] sel;
    logic             load;
    logic             have_req;

`ifdef PRIO_ENC_RR_EN
    logic [IDX_W-1:0] last;

    // Round-robin pick: every pending channel gets a distance measured
    // downward from the channel just below the last grant, and the nearest
    // one wins. With last at 0 the search starts at N-1, so the first grant
    // after reset matches the fixed-priority choice.
    always_comb begin
        int start;
        int dist;
        int best;
        sel   = '0;
        best  = N;
        dist  = 0;
        start = (last == '0) ? (N - 1) : (int'(last) - 1);
        for (int i = 0; i < N; i++) begin
            dist = start - i;
            if (dist < 0) begin
                dist = dist + N;
            end
            if (pending[i] && (dist < best)) begin
                best = dist;
                sel  = IDX_W'(i);
            end
        end
    end

    // Remember the most recent grant so the next search begins below it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= '0;
        end else if (load && have_req) begin
            last <= sel;
        end
    end
`else
    // Fixed priority: scanning upward lets the highest pending index win.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                sel = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state logic. The output register can reload when it is empty or
    // its current grant is being accepted. A reload with work available pops
    // the selected channel. New requests are ORed in after the pop so a
    // channel requested on the same edge it is granted stays pending.
    always_comb begin
        state_next = state;
        pop_mask   = '0;
        have_req   = |pending;
        load       = (state == EMPTY) || out_ready;
        if (load) begin
            if (have_req) begin
                state_next = FULL;
                pop_mask   = {{(N-1){1'b0}}, 1'b1} << sel;
            end else begin
                state_next = EMPTY;
            end
        end
        pending_next = (pending & ~pop_mask) | req_in;
    end

    // State, pending bits and output registers. The count tracks the value
    // pending is about to take, so it stays aligned with the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            pending    <= '0;
            pend_cnt   <= '0;
            out_idx    <= '0;
            out_onehot <= '0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            pend_cnt <= CNT_W'($countones(pending_next));
            if (load) begin
                if (have_req) begin
                    out_idx    <= sel;
                    out_onehot <= pop_mask;
                end else begin
                    out_idx    <= '0;
                    out_onehot <= '0;
                end
            end
        end
    end

    assign out_valid = (state == FULL);
    assign pend_any  = |pending;

endmodule

// File: tb/tb_prio_enc_queue.sv
// tb_prio_enc_queue
// ----------------------------------------------------------------------------
// Bench for prio_enc_queue. Three instances (N = 8, 3, 16) share clock, reset
// and out_ready. A behavioural model of each instance tracks the pending set
// and the held grant and is compared against every output one time unit after
// each clock or reset edge. Directed scenarios on top of that pin selected
// outputs to hand-derived literal values.
// ----------------------------------------------------------------------------
module tb_prio_enc_queue;

`ifdef PRIO_ENC_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  req8  = '0;
    logic [2:0]  req3  = '0;
    logic [15:0] req16 = '0;

    logic        v8,   v3,   v16;
    logic [2:0]  idx8;
    logic [1:0]  idx3;
    logic [3:0]  idx16;
    logic [7:0]  oh8;
    logic [2:0]  oh3;
    logic [15:0] oh16;
    logic [3:0]  cnt8;
    logic [1:0]  cnt3;
    logic [4:0]  cnt16;
    logic        any8, any3, any16;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: 0 -> N=8, 1 -> N=3, 2 -> N=16.
    int          m_n[3] = '{8, 3, 16};
    logic [63:0] m_pend[3];
    bit          m_valid[3];
    int          m_idx[3];
    int          m_last[3];

    prio_enc_queue #(.N(8)) u8 (
        .clk(clk), .rst(rst), .req_in(req8), .out_valid(v8), .out_ready(out_ready),
        .out_idx(idx8), .out_onehot(oh8), .pend_cnt(cnt8), .pend_any(any8)
    );

    prio_enc_queue #(.N(3)) u3 (
        .clk(clk), .rst(rst), .req_in(req3), .out_valid(v3), .out_ready(out_ready),
        .out_idx(idx3), .out_onehot(oh3), .pend_cnt(cnt3), .pend_any(any3)
    );

    prio_enc_queue #(.N(16)) u16 (
        .clk(clk), .rst(rst), .req_in(req16), .out_valid(v16), .out_ready(out_ready),
        .out_idx(idx16), .out_onehot(oh16), .pend_cnt(cnt16), .pend_any(any16)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Choose a winner among the pending channels: walk downward from the
    // starting index with wrap and take the first pending one.
    function automatic int pick(input logic [63:0] p, input int n, input int last);
        int start;
        int c;
        start = RR_MODE ? ((last + n - 1) % n) : (n - 1);
        for (int k = 0; k < n; k++) begin
            c = (start - k + n) % n;
            if (((p >> c) & 64'd1) != 64'd0) begin
                return c;
            end
        end
        return -1;
    endfunction

    function automatic logic [63:0] reqOf(input int k);
        case (k)
            0:       return 64'(req8);
            1:       return 64'(req3);
            default: return 64'(req16);
        endcase
    endfunction

    task automatic modelStep(input int k);
        logic [63:0] pop;
        int s;
        pop = '0;
        if (!m_valid[k] || out_ready) begin
            s = pick(m_pend[k], m_n[k], m_last[k]);
            if (s >= 0) begin
                m_valid[k] = 1'b1;
                m_idx[k]   = s;
                m_last[k]  = s;
                pop        = 64'd1 << s;
            end else begin
                m_valid[k] = 1'b0;
                m_idx[k]   = 0;
            end
        end
        m_pend[k] = (m_pend[k] & ~pop) | reqOf(k);
    endtask

    task automatic modelReset(input int k);
        m_pend[k]  = '0;
        m_valid[k] = 1'b0;
        m_idx[k]   = 0;
        m_last[k]  = 0;
    endtask

    task automatic compareInst(input int k);
        logic [63:0] e_oh;
        logic [63:0] e_cnt;
        logic [63:0] e_any;
        e_oh  = m_valid[k] ? (64'd1 << m_idx[k]) : 64'd0;
        e_cnt = 64'($countones(m_pend[k]));
        e_any = (m_pend[k] != '0) ? 64'd1 : 64'd0;
        case (k)
            0: begin
                checkOutput("n8.valid",  64'(v8),   64'(m_valid[k]));
                checkOutput("n8.idx",    64'(idx8), 64'(m_idx[k]));
                checkOutput("n8.onehot", 64'(oh8),  e_oh);
                checkOutput("n8.cnt",    64'(cnt8), e_cnt);
                checkOutput("n8.any",    64'(any8), e_any);
            end
            1: begin
                checkOutput("n3.valid",  64'(v3),   64'(m_valid[k]));
                checkOutput("n3.idx",    64'(idx3), 64'(m_idx[k]));
                checkOutput("n3.onehot", 64'(oh3),  e_oh);
                checkOutput("n3.cnt",    64'(cnt3), e_cnt);
                checkOutput("n3.any",    64'(any3), e_any);
            end
            default: begin
                checkOutput("n16.valid",  64'(v16),   64'(m_valid[k]));
                checkOutput("n16.idx",    64'(idx16), 64'(m_idx[k]));
                checkOutput("n16.onehot", 64'(oh16),  e_oh);
                checkOutput("n16.cnt",    64'(cnt16), e_cnt);
                checkOutput("n16.any",    64'(any16), e_any);
            end
        endcase
    endtask

    // Advance the model on every clock or reset edge, then compare all three
    // instances once their registers have settled.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                modelReset(k);
            end else begin
                modelStep(k);
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            compareInst(k);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] r8, input logic [2:0] r3,
                                 input logic [15:0] r16, input logic rdy);
        req8      = r8;
        req3      = r3;
        req16     = r16;
        out_ready = rdy;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_starve[6];
    int exp_ff[9];

    initial begin
        for (int k = 0; k < 3; k++) begin
            modelReset(k);
        end
        #1 rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset while work is pending and a grant is held.
        $display("[TB] reset while busy");
        applyStimulus(8'hFF, 3'b000, 16'h0000, 1'b0);
        step();
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b0);
        step();
        checkOutput("busy.valid", 64'(v8), 64'd1);
        checkOutput("busy.cnt",   64'(cnt8), 64'd7);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst.valid",  64'(v8),   64'd0);
        checkOutput("rst.idx",    64'(idx8), 64'd0);
        checkOutput("rst.onehot", 64'(oh8),  64'd0);
        checkOutput("rst.cnt",    64'(cnt8), 64'd0);
        checkOutput("rst.any",    64'(any8), 64'd0);
        step();
        rst = 1'b0;
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b1);
        step();
        step();
        checkOutput("idle.valid", 64'(v8),   64'd0);
        checkOutput("idle.cnt",   64'(cnt8), 64'd0);

        // Burst drain of channels 7, 5 and 2.
        $display("[TB] burst drain");
        applyReset();
        applyStimulus(8'hA4, 3'b000, 16'h0000, 1'b1);
        step();
        checkOutput("burst.valid0", 64'(v8),   64'd0);
        checkOutput("burst.cnt0",   64'(cnt8), 64'd3);
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b1);
        step();
        checkOutput("burst.idx1", 64'(idx8), 64'd7);
        checkOutput("burst.oh1",  64'(oh8),  64'h80);
        checkOutput("burst.cnt1", 64'(cnt8), 64'd2);
        step();
        checkOutput("burst.idx2", 64'(idx8), 64'd5);
        checkOutput("burst.oh2",  64'(oh8),  64'h20);
        checkOutput("burst.cnt2", 64'(cnt8), 64'd1);
        step();
        checkOutput("burst.idx3", 64'(idx8), 64'd2);
        checkOutput("burst.oh3",  64'(oh8),  64'h04);
        checkOutput("burst.cnt3", 64'(cnt8), 64'd0);
        step();
        checkOutput("burst.valid4", 64'(v8),   64'd0);
        checkOutput("burst.idx4",   64'(idx8), 64'd0);

        // Back-pressure: grant 7 held for five stalled cycles, with channel 7
        // requested again during the stall.
        $display("[TB] back-pressure");
        applyReset();
        applyStimulus(8'h80, 3'b000, 16'h0000, 1'b0);
        step();
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b0);
        step();
        checkOutput("bp.valid", 64'(v8),   64'd1);
        checkOutput("bp.idx",   64'(idx8), 64'd7);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp.hold_idx",   64'(idx8), 64'd7);
            checkOutput("bp.hold_valid", 64'(v8),   64'd1);
            applyStimulus((i == 1) ? 8'h80 : 8'h00, 3'b000, 16'h0000, 1'b0);
        end
        checkOutput("bp.pend_during_stall", 64'(cnt8), 64'd1);
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b1);
        step();
        checkOutput("bp.regrant_valid", 64'(v8),   64'd1);
        checkOutput("bp.regrant_idx",   64'(idx8), 64'd7);
        checkOutput("bp.regrant_cnt",   64'(cnt8), 64'd0);
        step();
        checkOutput("bp.empty", 64'(v8), 64'd0);

        // Request on the same edge the channel is popped keeps it pending.
        $display("[TB] set wins over clear");
        applyReset();
        applyStimulus(8'h20, 3'b000, 16'h0000, 1'b1);
        step();
        applyStimulus(8'h20, 3'b000, 16'h0000, 1'b1);
        step();
        checkOutput("sw.idx1", 64'(idx8), 64'd5);
        checkOutput("sw.cnt1", 64'(cnt8), 64'd1);
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b1);
        step();
        checkOutput("sw.valid2", 64'(v8),   64'd1);
        checkOutput("sw.idx2",   64'(idx8), 64'd5);
        step();
        checkOutput("sw.valid3", 64'(v8), 64'd0);

        // Channels 7 and 0 requested continuously.
        $display("[TB] starvation pattern");
        for (int j = 0; j < 6; j++) begin
            exp_starve[j] = (RR_MODE && (j % 2 == 1)) ? 0 : 7;
        end
        applyReset();
        applyStimulus(8'h81, 3'b000, 16'h0000, 1'b1);
        step();
        for (int j = 0; j < 6; j++) begin
            step();
            checkOutput("starve.idx", 64'(idx8), 64'(exp_starve[j]));
        end

        // Every channel requested continuously.
        $display("[TB] all channels held");
        for (int j = 0; j < 9; j++) begin
            exp_ff[j] = RR_MODE ? ((15 - j) % 8) : 7;
        end
        applyReset();
        applyStimulus(8'hFF, 3'b000, 16'h0000, 1'b1);
        step();
        for (int j = 0; j < 9; j++) begin
            step();
            checkOutput("ff.idx", 64'(idx8), 64'(exp_ff[j]));
        end

        // Drain all ones on the N=3 and N=16 instances.
        $display("[TB] parametric drain");
        applyReset();
        applyStimulus(8'h00, 3'b111, 16'hFFFF, 1'b1);
        step();
        checkOutput("n3.cnt_start",  64'(cnt3),  64'd3);
        checkOutput("n16.cnt_start", 64'(cnt16), 64'd16);
        checkOutput("n16.valid0",    64'(v16),   64'd0);
        applyStimulus(8'h00, 3'b000, 16'h0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step();
            checkOutput("n16.seq", 64'(idx16), 64'(15 - k));
            checkOutput("n16.seq_valid", 64'(v16), 64'd1);
            if (k < 3) begin
                checkOutput("n3.seq", 64'(idx3), 64'(2 - k));
            end else if (k == 3) begin
                checkOutput("n3.done", 64'(v3), 64'd0);
            end
        end
        step();
        checkOutput("n16.done", 64'(v16), 64'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
